// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID stage: default widths, control-bundle
// bit indices and the R-type opcode value.
package mips_pkg;

    localparam int unsigned DEF_NB_DATA   = 32;
    localparam int unsigned DEF_NB_ADDR   = 5;
    localparam int unsigned DEF_NB_PC     = 32;
    localparam int unsigned DEF_NB_OPCODE = 6;
    localparam int unsigned DEF_NB_CTRL   = 12;

    // Bit positions inside the packed control bundle
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_TO_REG = 1;
    localparam int unsigned CTRL_MEM_WR     = 2;
    localparam int unsigned CTRL_MEM_RD     = 3;

    // Opcode value that selects funct as the ALU operation
    localparam int unsigned OPCODE_RTYPE = 0;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Bus bundle between IF/ID, writeback, debug and the ID/EX register.
// slave = the decode stage, master = whoever drives it.
interface instruction_decode_stage_if #(
    parameter int unsigned NB_DATA   = mips_pkg::DEF_NB_DATA,
    parameter int unsigned NB_ADDR   = mips_pkg::DEF_NB_ADDR,
    parameter int unsigned NB_PC     = mips_pkg::DEF_NB_PC,
    parameter int unsigned NB_OPCODE = mips_pkg::DEF_NB_OPCODE,
    parameter int unsigned NB_CTRL   = mips_pkg::DEF_NB_CTRL
);

    logic                 i_enable;
    logic                 i_flush;
    logic [NB_DATA-1:0]   i_instruction;
    logic [NB_PC-1:0]     i_pc_plus4;
    logic [NB_CTRL-1:0]   i_ctrl;
    logic                 i_imm_signed;
    logic                 i_uses_rt;
    logic                 i_wb_wr_enb;
    logic [NB_ADDR-1:0]   i_wb_wr_addr;
    logic [NB_DATA-1:0]   i_wb_data;
    logic [NB_ADDR-1:0]   i_dbg_addr;
    logic [NB_DATA-1:0]   o_dbg_data;
    logic                 o_stall;
    logic [NB_DATA-1:0]   o_rs_data;
    logic [NB_DATA-1:0]   o_rt_data;
    logic [NB_DATA-1:0]   o_imm;
    logic [NB_ADDR-1:0]   o_sa;
    logic [NB_OPCODE-1:0] o_alu_opcode;
    logic [NB_ADDR-1:0]   o_rs_addr;
    logic [NB_ADDR-1:0]   o_rt_addr;
    logic [NB_ADDR-1:0]   o_rd_addr;
    logic [NB_PC-1:0]     o_branch_target;
    logic [NB_PC-1:0]     o_pc_plus4;
    logic [NB_CTRL-1:0]   o_ctrl;

    modport slave (
        input  i_enable, i_flush, i_instruction, i_pc_plus4, i_ctrl, i_imm_signed,
        input  i_uses_rt, i_wb_wr_enb, i_wb_wr_addr, i_wb_data, i_dbg_addr,
        output o_dbg_data, o_stall, o_rs_data, o_rt_data, o_imm, o_sa, o_alu_opcode,
        output o_rs_addr, o_rt_addr, o_rd_addr, o_branch_target, o_pc_plus4, o_ctrl
    );

    modport master (
        output i_enable, i_flush, i_instruction, i_pc_plus4, i_ctrl, i_imm_signed,
        output i_uses_rt, i_wb_wr_enb, i_wb_wr_addr, i_wb_data, i_dbg_addr,
        input  o_dbg_data, o_stall, o_rs_data, o_rt_data, o_imm, o_sa, o_alu_opcode,
        input  o_rs_addr, o_rt_addr, o_rd_addr, o_branch_target, o_pc_plus4, o_ctrl
    );

endinterface

// File: rtl/register_file_bypass.sv
// Register file: two operand read ports plus a debug port, one write port.
// Operand ports see a same-cycle write (write-through); the debug port does not.
// Register 0 is hard-wired to zero.
module register_file_bypass #(
    parameter int unsigned NB_DATA = mips_pkg::DEF_NB_DATA,
    parameter int unsigned NB_ADDR = mips_pkg::DEF_NB_ADDR
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_wr_enb,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr_a,
    input  logic [NB_ADDR-1:0] i_rd_addr_b,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_rd_data_a,
    output logic [NB_DATA-1:0] o_rd_data_b,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int unsigned NREGS = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] regs_q [NREGS];
    logic [NB_DATA-1:0] regs_d [NREGS];
    logic               wr_active;

    assign wr_active = i_wr_enb && (i_wr_addr != '0);

    // Next-state of the array: at most one register changes per cycle
    always_comb begin
        regs_d = regs_q;
        if (wr_active) begin
            regs_d[i_wr_addr] = i_wr_data;
        end
    end

    // Storage with asynchronous clear
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: r0 forced to zero, operand ports forward an in-flight write
    always_comb begin
        o_rd_data_a = '0;
        o_rd_data_b = '0;
        o_dbg_data  = '0;
        if (i_rd_addr_a != '0) begin
            o_rd_data_a = (wr_active && i_wr_addr == i_rd_addr_a) ? i_wr_data
                                                                  : regs_q[i_rd_addr_a];
        end
        if (i_rd_addr_b != '0) begin
            o_rd_data_b = (wr_active && i_wr_addr == i_rd_addr_b) ? i_wr_data
                                                                  : regs_q[i_rd_addr_b];
        end
        if (i_dbg_addr != '0) begin
            o_dbg_data = regs_q[i_dbg_addr];
        end
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: field decode, immediate extension, branch target, load-use
// hazard detection and the ID/EX pipeline register.
module instruction_decode_stage
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA   = DEF_NB_DATA,
    parameter int unsigned NB_ADDR   = DEF_NB_ADDR,
    parameter int unsigned NB_PC     = DEF_NB_PC,
    parameter int unsigned NB_OPCODE = DEF_NB_OPCODE,
    parameter int unsigned NB_CTRL   = DEF_NB_CTRL
) (
    input logic                       i_clock,
    input logic                       i_reset_n,
    instruction_decode_stage_if.slave bus
);

    // Field layout: opcode | rs | rt | imm (imm overlays rd | sa | funct)
    localparam int unsigned NB_IMM = NB_DATA - NB_OPCODE - 2 * NB_ADDR;
    localparam int unsigned RS_MSB = NB_DATA - NB_OPCODE - 1;
    localparam int unsigned RT_MSB = RS_MSB - NB_ADDR;
    localparam int unsigned RD_MSB = NB_IMM - 1;
    localparam int unsigned SA_MSB = RD_MSB - NB_ADDR;

    logic [NB_OPCODE-1:0] opcode;
    logic [NB_OPCODE-1:0] funct;
    logic [NB_ADDR-1:0]   rs;
    logic [NB_ADDR-1:0]   rt;
    logic [NB_ADDR-1:0]   rd;
    logic [NB_ADDR-1:0]   sa;
    logic [NB_IMM-1:0]    imm16;
    logic [NB_OPCODE-1:0] alu_opcode;
    logic [NB_DATA-1:0]   imm_ext;
    logic [NB_PC-1:0]     imm_pc;
    logic [NB_PC-1:0]     branch_target;
    logic [NB_DATA-1:0]   rs_rd_data;
    logic [NB_DATA-1:0]   rt_rd_data;
    logic                 stall;
    logic                 bubble;

    logic [NB_DATA-1:0]   rs_data_q, rs_data_d;
    logic [NB_DATA-1:0]   rt_data_q, rt_data_d;
    logic [NB_DATA-1:0]   imm_q, imm_d;
    logic [NB_ADDR-1:0]   sa_q, sa_d;
    logic [NB_OPCODE-1:0] alu_opcode_q, alu_opcode_d;
    logic [NB_ADDR-1:0]   rs_addr_q, rs_addr_d;
    logic [NB_ADDR-1:0]   rt_addr_q, rt_addr_d;
    logic [NB_ADDR-1:0]   rd_addr_q, rd_addr_d;
    logic [NB_PC-1:0]     branch_target_q, branch_target_d;
    logic [NB_PC-1:0]     pc_plus4_q, pc_plus4_d;
    logic [NB_CTRL-1:0]   ctrl_q, ctrl_d;

    register_file_bypass #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_regfile (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_wr_enb    (bus.i_wb_wr_enb && bus.i_enable),
        .i_wr_addr   (bus.i_wb_wr_addr),
        .i_wr_data   (bus.i_wb_data),
        .i_rd_addr_a (rs),
        .i_rd_addr_b (rt),
        .i_dbg_addr  (bus.i_dbg_addr),
        .o_rd_data_a (rs_rd_data),
        .o_rd_data_b (rt_rd_data),
        .o_dbg_data  (bus.o_dbg_data)
    );

    // Field extraction, ALU op select, immediate extension and branch target
    always_comb begin
        opcode     = bus.i_instruction[NB_DATA-1 -: NB_OPCODE];
        rs         = bus.i_instruction[RS_MSB -: NB_ADDR];
        rt         = bus.i_instruction[RT_MSB -: NB_ADDR];
        rd         = bus.i_instruction[RD_MSB -: NB_ADDR];
        sa         = bus.i_instruction[SA_MSB -: NB_ADDR];
        funct      = bus.i_instruction[NB_OPCODE-1:0];
        imm16      = bus.i_instruction[NB_IMM-1:0];
        alu_opcode = (opcode == NB_OPCODE'(OPCODE_RTYPE)) ? funct : opcode;
        imm_ext    = bus.i_imm_signed ? {{(NB_DATA-NB_IMM){imm16[NB_IMM-1]}}, imm16}
                                      : {{(NB_DATA-NB_IMM){1'b0}}, imm16};
        // Branch offsets are always signed, whatever i_imm_signed says
        imm_pc        = {{(NB_PC-NB_IMM){imm16[NB_IMM-1]}}, imm16};
        branch_target = bus.i_pc_plus4 + (imm_pc << 2);
    end

    // Load-use hazard: a load in EX targets a register this instruction reads
    always_comb begin
        stall = ctrl_q[CTRL_MEM_RD] && (rt_addr_q != '0) &&
                ((rt_addr_q == rs) || (bus.i_uses_rt && (rt_addr_q == rt))) &&
                !bus.i_flush;
        bubble = bus.i_flush || stall;
    end

    // ID/EX next state: hold when frozen, bubble on flush/stall, else load
    always_comb begin
        rs_data_d       = rs_data_q;
        rt_data_d       = rt_data_q;
        imm_d           = imm_q;
        sa_d            = sa_q;
        alu_opcode_d    = alu_opcode_q;
        rs_addr_d       = rs_addr_q;
        rt_addr_d       = rt_addr_q;
        rd_addr_d       = rd_addr_q;
        branch_target_d = branch_target_q;
        pc_plus4_d      = pc_plus4_q;
        ctrl_d          = ctrl_q;
        if (bus.i_enable) begin
            if (bubble) begin
                rs_data_d       = '0;
                rt_data_d       = '0;
                imm_d           = '0;
                sa_d            = '0;
                alu_opcode_d    = '0;
                rs_addr_d       = '0;
                rt_addr_d       = '0;
                rd_addr_d       = '0;
                branch_target_d = '0;
                pc_plus4_d      = '0;
                ctrl_d          = '0;
            end else begin
                rs_data_d       = rs_rd_data;
                rt_data_d       = rt_rd_data;
                imm_d           = imm_ext;
                sa_d            = sa;
                alu_opcode_d    = alu_opcode;
                rs_addr_d       = rs;
                rt_addr_d       = rt;
                rd_addr_d       = rd;
                branch_target_d = branch_target;
                pc_plus4_d      = bus.i_pc_plus4;
                ctrl_d          = bus.i_ctrl;
            end
        end
    end

    // ID/EX register with asynchronous clear
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rs_data_q       <= '0;
            rt_data_q       <= '0;
            imm_q           <= '0;
            sa_q            <= '0;
            alu_opcode_q    <= '0;
            rs_addr_q       <= '0;
            rt_addr_q       <= '0;
            rd_addr_q       <= '0;
            branch_target_q <= '0;
            pc_plus4_q      <= '0;
            ctrl_q          <= '0;
        end else begin
            rs_data_q       <= rs_data_d;
            rt_data_q       <= rt_data_d;
            imm_q           <= imm_d;
            sa_q            <= sa_d;
            alu_opcode_q    <= alu_opcode_d;
            rs_addr_q       <= rs_addr_d;
            rt_addr_q       <= rt_addr_d;
            rd_addr_q       <= rd_addr_d;
            branch_target_q <= branch_target_d;
            pc_plus4_q      <= pc_plus4_d;
            ctrl_q          <= ctrl_d;
        end
    end

    assign bus.o_stall         = stall;
    assign bus.o_rs_data       = rs_data_q;
    assign bus.o_rt_data       = rt_data_q;
    assign bus.o_imm           = imm_q;
    assign bus.o_sa            = sa_q;
    assign bus.o_alu_opcode    = alu_opcode_q;
    assign bus.o_rs_addr       = rs_addr_q;
    assign bus.o_rt_addr       = rt_addr_q;
    assign bus.o_rd_addr       = rd_addr_q;
    assign bus.o_branch_target = branch_target_q;
    assign bus.o_pc_plus4      = pc_plus4_q;
    assign bus.o_ctrl          = ctrl_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: decode vector table, directed hazard,
// bypass, freeze and reset sequences, then random traffic against a model.
module tb_instruction_decode_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    instruction_decode_stage_if bus ();

    instruction_decode_stage dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  sa;
        logic [5:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] bt;
        logic [31:0] pc4;
        logic [11:0] ctrl;
    } idex_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        sgn;
        logic [31:0] imm;
        logic [31:0] bt;
        logic [5:0]  alu;
        logic [4:0]  sa;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } vec_t;

    localparam logic [11:0] CTRL_LW  = 12'h00B;
    localparam logic [11:0] CTRL_ALU = 12'h001;

    logic [31:0] m_regs [32];
    idex_t       m_idex;
    vec_t        vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [31:0] instr, input logic [31:0] pc4,
                          input logic [11:0] ctrl, input logic sgn, input logic uses,
                          input logic flush, input logic en, input logic wben,
                          input logic [4:0] wba, input logic [31:0] wbd,
                          input logic [4:0] dbg);
        bus.i_instruction = instr;
        bus.i_pc_plus4    = pc4;
        bus.i_ctrl        = ctrl;
        bus.i_imm_signed  = sgn;
        bus.i_uses_rt     = uses;
        bus.i_flush       = flush;
        bus.i_enable      = en;
        bus.i_wb_wr_enb   = wben;
        bus.i_wb_wr_addr  = wba;
        bus.i_wb_data     = wbd;
        bus.i_dbg_addr    = dbg;
    endtask

    function automatic logic [4:0] f_rs(input logic [31:0] ins);
        return 5'((ins >> 21) & 32'h1f);
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ins);
        return 5'((ins >> 16) & 32'h1f);
    endfunction

    // Operand value as seen by an instruction in ID this cycle
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.i_enable && bus.i_wb_wr_enb && bus.i_wb_wr_addr == a) return bus.i_wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        logic [31:0] ins;
        ins = bus.i_instruction;
        return m_idex.ctrl[3] && m_idex.rt != 0 && !bus.i_flush &&
               (m_idex.rt == f_rs(ins) || (bus.i_uses_rt && m_idex.rt == f_rt(ins)));
    endfunction

    task automatic check_outputs();
        chk("rs_data", bus.o_rs_data, m_idex.rs_data);
        chk("rt_data", bus.o_rt_data, m_idex.rt_data);
        chk("imm", bus.o_imm, m_idex.imm);
        chk("sa", bus.o_sa, m_idex.sa);
        chk("alu_opcode", bus.o_alu_opcode, m_idex.alu);
        chk("rs_addr", bus.o_rs_addr, m_idex.rs);
        chk("rt_addr", bus.o_rt_addr, m_idex.rt);
        chk("rd_addr", bus.o_rd_addr, m_idex.rd);
        chk("branch_target", bus.o_branch_target, m_idex.bt);
        chk("pc_plus4", bus.o_pc_plus4, m_idex.pc4);
        chk("ctrl", bus.o_ctrl, m_idex.ctrl);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, bus.o_stall, 0);
        chk({tag, "_idex"}, {bus.o_rs_data, bus.o_rt_data, bus.o_imm, bus.o_sa,
            bus.o_alu_opcode, bus.o_rs_addr, bus.o_rt_addr, bus.o_rd_addr,
            bus.o_branch_target, bus.o_pc_plus4, bus.o_ctrl} == '0, 1);
    endtask

    // Called at a falling edge with inputs applied; ends at the next falling edge
    task automatic do_cycle();
        idex_t       nxt;
        logic        st;
        logic [31:0] ins;
        logic [31:0] simm;
        logic [31:0] opc;
        logic        wr;
        #1;
        st = m_stall();
        chk("stall", bus.o_stall, st);
        chk("dbg_data", bus.o_dbg_data, (bus.i_dbg_addr == 0) ? 32'h0 : m_regs[bus.i_dbg_addr]);
        ins = bus.i_instruction;
        nxt = m_idex;
        if (bus.i_enable) begin
            if (bus.i_flush || st) begin
                nxt = '0;
            end else begin
                simm = ins & 32'hFFFF;
                if (simm >= 32'h8000) simm = simm - 32'h10000;
                opc         = ins >> 26;
                nxt.rs_data = m_read(f_rs(ins));
                nxt.rt_data = m_read(f_rt(ins));
                nxt.imm     = bus.i_imm_signed ? simm : (ins & 32'hFFFF);
                nxt.sa      = 5'((ins >> 6) & 32'h1f);
                nxt.alu     = (opc == 0) ? 6'(ins & 32'h3f) : 6'(opc);
                nxt.rs      = f_rs(ins);
                nxt.rt      = f_rt(ins);
                nxt.rd      = 5'((ins >> 11) & 32'h1f);
                nxt.bt      = bus.i_pc_plus4 + simm * 4;
                nxt.pc4     = bus.i_pc_plus4;
                nxt.ctrl    = bus.i_ctrl;
            end
        end
        wr = bus.i_enable && bus.i_wb_wr_enb && bus.i_wb_wr_addr != 0;
        @(posedge clk);
        m_idex = nxt;
        if (wr) m_regs[bus.i_wb_wr_addr] = bus.i_wb_data;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic model_clear();
        m_idex = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        vecs[0] = '{32'h2001FFFC, 32'h100,  1'b1, 32'hFFFFFFFC, 32'h000000F0, 6'h08, 5'd31,
                    5'd0, 5'd1,  5'd31};
        vecs[1] = '{32'h2001FFFC, 32'h100,  1'b0, 32'h0000FFFC, 32'h000000F0, 6'h08, 5'd31,
                    5'd0, 5'd1,  5'd31};
        vecs[2] = '{32'h00640820, 32'h200,  1'b1, 32'h00000820, 32'h00002280, 6'h20, 5'd0,
                    5'd3, 5'd4,  5'd1};
        vecs[3] = '{32'h8C220000, 32'h40,   1'b1, 32'h00000000, 32'h00000040, 6'h23, 5'd0,
                    5'd1, 5'd2,  5'd0};
        vecs[4] = '{32'h00031100, 32'h8,    1'b1, 32'h00001100, 32'h00004408, 6'h00, 5'd4,
                    5'd0, 5'd3,  5'd2};
        vecs[5] = '{32'h1000FFFF, 32'h0,    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 6'h04, 5'd31,
                    5'd0, 5'd0,  5'd31};
        vecs[6] = '{32'h3C0A8000, 32'h1000, 1'b0, 32'h00008000, 32'hFFFE1000, 6'h0F, 5'd0,
                    5'd0, 5'd10, 5'd16};

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_all_zero("por");
        rst_n = 1'b1;

        // Decode table
        foreach (vecs[i]) begin
            set_in(vecs[i].instr, vecs[i].pc4, CTRL_ALU, vecs[i].sgn, 1, 0, 1, 0, 0, 0, 0);
            do_cycle();
            chk("tbl_imm", bus.o_imm, vecs[i].imm);
            chk("tbl_bt", bus.o_branch_target, vecs[i].bt);
            chk("tbl_alu", bus.o_alu_opcode, vecs[i].alu);
            chk("tbl_fields", {bus.o_sa, bus.o_rs_addr, bus.o_rt_addr, bus.o_rd_addr},
                {vecs[i].sa, vecs[i].rs, vecs[i].rt, vecs[i].rd});
        end

        // Write-through bypass of r3 while add r1,r3,r4 is in ID
        set_in(32'h00640820, 32'h10, CTRL_ALU, 1, 1, 0, 1, 1, 3, 32'hDEADBEEF, 3);
        do_cycle();
        chk("bypass_rs", bus.o_rs_data, 32'hDEADBEEF);
        set_in(32'h00640820, 32'h10, CTRL_ALU, 1, 1, 0, 1, 0, 0, 0, 3);
        do_cycle();
        chk("stored_rs", bus.o_rs_data, 32'hDEADBEEF);

        // Load-use: lw r2,0(r1) then add r5,r2,r6
        set_in(32'h8C220000, 32'h20, CTRL_LW, 1, 0, 0, 1, 0, 0, 0, 0);
        do_cycle();
        set_in(32'h00462820, 32'h24, CTRL_ALU, 1, 1, 0, 1, 0, 0, 0, 0);
        #1 chk("lu_stall", bus.o_stall, 1);
        do_cycle();
        chk("lu_bubble_ctrl", bus.o_ctrl, 0);
        chk("lu_stall_drop", bus.o_stall, 0);
        do_cycle();
        chk("lu_add_rd", bus.o_rd_addr, 5);
        chk("lu_add_ctrl", bus.o_ctrl, CTRL_ALU);

        // lw r0 then a use of r0: no stall; write to r0 ignored
        set_in(32'h8C200000, 32'h30, CTRL_LW, 1, 0, 0, 1, 0, 0, 0, 0);
        do_cycle();
        set_in(32'h00002820, 32'h34, CTRL_ALU, 1, 1, 0, 1, 1, 0, 32'h1234, 0);
        #1 chk("r0_no_stall", bus.o_stall, 0);
        do_cycle();
        chk("r0_rs_data", bus.o_rs_data, 0);
        chk("r0_dbg", bus.o_dbg_data, 0);

        // Flush during a load-use hazard wins over stall
        set_in(32'h8C220000, 32'h40, CTRL_LW, 1, 0, 0, 1, 0, 0, 0, 0);
        do_cycle();
        set_in(32'h00462820, 32'h44, CTRL_ALU, 1, 1, 1, 1, 0, 0, 0, 0);
        #1 chk("flush_stall", bus.o_stall, 0);
        do_cycle();
        chk("flush_bubble", {bus.o_ctrl, bus.o_rd_addr}, 0);
        set_in(32'h00462820, 32'h44, CTRL_ALU, 1, 1, 0, 1, 0, 0, 0, 0);
        do_cycle();

        // Freeze three cycles: state held, WB write dropped
        for (int i = 0; i < 3; i++) begin
            set_in(32'h2001FFFC, 32'h50, CTRL_LW, 1, 1, 0, 0, 1, 7, 32'h55, 7);
            do_cycle();
            chk("freeze_hold", {bus.o_rd_addr, bus.o_ctrl, bus.o_pc_plus4},
                {5'd5, CTRL_ALU, 32'h44});
        end
        set_in(32'h00000000, 32'h54, 0, 1, 1, 0, 1, 0, 0, 0, 7);
        #1 chk("freeze_wb_dropped", bus.o_dbg_data, 0);
        do_cycle();

        // Frozen pipeline keeps the stall request up
        set_in(32'h8C220000, 32'h60, CTRL_LW, 1, 0, 0, 1, 0, 0, 0, 0);
        do_cycle();
        for (int i = 0; i < 2; i++) begin
            set_in(32'h00462820, 32'h64, CTRL_ALU, 1, 1, 0, 0, 0, 0, 0, 0);
            #1 chk("frozen_stall", bus.o_stall, 1);
            do_cycle();
        end
        set_in(32'h00462820, 32'h64, CTRL_ALU, 1, 1, 0, 1, 0, 0, 0, 0);
        do_cycle();
        do_cycle();

        // Reset mid-run with a stall pending
        set_in(32'h00000000, 32'h70, 0, 1, 0, 0, 1, 1, 5, 32'h77, 5);
        do_cycle();
        set_in(32'h8C220000, 32'h74, CTRL_LW, 1, 0, 0, 1, 0, 0, 0, 5);
        do_cycle();
        chk("pre_reset_r5", bus.o_dbg_data, 32'h77);
        set_in(32'h00462820, 32'h78, CTRL_ALU, 1, 1, 0, 1, 0, 0, 0, 5);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(32'h00000000, 32'h0, 0, 1, 0, 0, 1, 0, 0, 0, 5);
        #1 chk("post_reset_r5", bus.o_dbg_data, 0);
        do_cycle();

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [11:0] ctl;
            ins = $urandom;
            if ($urandom_range(1, 0) == 0) ins[31:26] = 6'h0;
            ins[25:21] = 5'($urandom_range(3, 0));
            ins[20:16] = 5'($urandom_range(3, 0));
            ctl = 12'($urandom);
            ctl[3] = ($urandom_range(9, 0) < 3);
            set_in(ins, $urandom, ctl, 1'($urandom), 1'($urandom),
                   ($urandom_range(9, 0) == 0), ($urandom_range(19, 0) > 2),
                   1'($urandom), 5'($urandom_range(3, 0)), $urandom,
                   5'($urandom_range(3, 0)));
            do_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
